// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider and the ALU condition logic.
package div_pkg;

  localparam int DIV_N = 32;
  localparam int CNT_W = $clog2(DIV_N + 1);

  // Flag bit positions, common with the ALU flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FIXUP = 3'd2,
    DZERO = 3'd3,
    DONE  = 3'd4
  } div_state_t;

endpackage

// File: rtl/seq_divider_step.sv
// One radix-2 restoring iteration: shift {rem, dvd} left, trial-subtract the divisor magnitude.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] dvd,
  input  logic [N-1:0] dmag,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] dvd_next,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] trial;

  // A set top bit in the shifted remainder already exceeds any N-bit divisor,
  // otherwise the sign bit of the N+1-bit difference decides.
  always_comb begin
    shifted  = {rem, dvd[N-1]};
    trial    = shifted - {1'b0, dmag};
    q_bit    = shifted[N] | ~trial[N];
    rem_next = q_bit ? trial[N-1:0] : shifted[N-1:0];
    dvd_next = {dvd[N-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider with start/done handshake, sign fixup and ALU-style flags.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic [3:0]   flags,
  output div_state_t   fsm_state
);

  // Handshake: start is taken on any rising edge where the state is IDLE or
  // DONE; busy covers CALC/FIXUP/DZERO; done is high for the DONE cycle only.

  localparam int CW = $clog2(N + 1);

  div_state_t     state, state_next;
  logic           load, step, fix_write, dz_write;
  logic [N-1:0]   rem, dvd, dmag, dvd_raw;
  logic [CW-1:0]  cnt;
  logic           neg_q, neg_r;
  logic [N-1:0]   rem_next, dvd_next;
  logic           q_bit;
  logic [N-1:0]   a_mag, b_mag;
  logic [N-1:0]   q_fix, r_fix, res_q, res_r;
  logic [3:0]     res_flags;

  div_step #(.N(N)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .dmag     (dmag),
    .rem_next (rem_next),
    .dvd_next (dvd_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fix_write  = 1'b0;
    dz_write   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (divisor == '0) ? DZERO : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(1)) state_next = FIXUP;
      end
      FIXUP: begin
        fix_write  = 1'b1;
        state_next = DONE;
      end
      DZERO: begin
        dz_write   = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == CALC) || (state == FIXUP) || (state == DZERO);
  assign done      = (state == DONE);
  assign fsm_state = state;

  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign a_mag = (signed_op && dividend[N-1]) ? -dividend : dividend;
  assign b_mag = (signed_op && divisor[N-1])  ? -divisor  : divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      dvd     <= '0;
      dmag    <= '0;
      dvd_raw <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (load) begin
      rem     <= '0;
      dvd     <= a_mag;
      dmag    <= b_mag;
      dvd_raw <= dividend;
      cnt     <= CW'(N);
      neg_q   <= signed_op & (dividend[N-1] ^ divisor[N-1]);
      neg_r   <= signed_op & dividend[N-1];
    end else if (step) begin
      rem <= rem_next;
      dvd <= dvd_next;
      cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    q_fix = neg_q ? -dvd : dvd;
    r_fix = neg_r ? -rem : rem;
    res_q = q_fix;
    res_r = r_fix;
    if (dz_write) begin
      res_q = '1;
      res_r = dvd_raw;
    end
    res_flags         = '0;
    res_flags[FLAG_N] = res_q[N-1];
    res_flags[FLAG_Z] = (res_q == '0);
    res_flags[FLAG_C] = 1'b0;
    res_flags[FLAG_V] = 1'b0;
  end

  // Results change only on entry to DONE, so the previous result stays readable while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      flags       <= 4'b0100;
    end else if (fix_write || dz_write) begin
      quotient    <= res_q;
      remainder   <= res_r;
      div_by_zero <= dz_write;
      flags       <= res_flags;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  import div_pkg::*;

  logic        clk, reset, start, signed_op;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  logic [3:0]  flags;
  div_state_t  fsm_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  seq_divider #(.N(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .flags       (flags),
    .fsm_state   (fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output logic [3:0] f, output int lat);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 2;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dz = 1'b0; lat = 34;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = 34;
    end
    f = {q[31], (q == 32'd0), 2'b00};
  endfunction

  // Runs one division; optionally pokes start mid-operation, or chains the next start at DONE.
  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int poke_at, input bit pre_driven,
                        input bit chain, input logic [31:0] na, input logic [31:0] nb,
                        input logic ns);
    logic [31:0] eq, er;
    logic        edz;
    logic [3:0]  ef;
    int          elat, cyc;
    bit          bad_busy;
    model(a, b, s, eq, er, edz, ef, elat);
    if (!pre_driven) begin
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b; signed_op = s;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom_range(0, 1));
    cyc = 1;
    bad_busy = 1'b0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1 || quotient !== prev_q || remainder !== prev_r) bad_busy = 1'b1;
      if (cyc == poke_at) begin
        start = 1'b1; dividend = 32'd1; divisor = 32'd1; signed_op = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc !== elat) begin n_bad++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, elat); end
    n_cmp++; if (bad_busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_hold: got 1 expected 0 (busy low or outputs changed early)", name); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy); end
    n_cmp++; if (quotient !== eq) begin n_bad++; $display("FAIL %s quotient: got %h expected %h", name, quotient, eq); end
    n_cmp++; if (remainder !== er) begin n_bad++; $display("FAIL %s remainder: got %h expected %h", name, remainder, er); end
    n_cmp++; if (div_by_zero !== edz) begin n_bad++; $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edz); end
    n_cmp++; if (flags !== ef) begin n_bad++; $display("FAIL %s flags: got %b expected %b", name, flags, ef); end
    prev_q = eq;
    prev_r = er;
    if (chain) begin
      start = 1'b1; dividend = na; divisor = nb; signed_op = ns;
    end else begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, done, busy); end
      n_cmp++; if (quotient !== eq || remainder !== er) begin n_bad++; $display("FAIL %s held: got %h/%h expected %h/%h", name, quotient, remainder, eq, er); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset busy/done: got %b/%b expected 0/0", busy, done); end
    n_cmp++; if (quotient !== 32'd0 || remainder !== 32'd0) begin n_bad++; $display("FAIL reset results: got %h/%h expected 0/0", quotient, remainder); end
    n_cmp++; if (div_by_zero !== 1'b0 || flags !== 4'b0100) begin n_bad++; $display("FAIL reset flags: got dz=%b flags=%b expected 0/0100", div_by_zero, flags); end
    reset = 1'b0;
    prev_q = '0; prev_r = '0;
  endtask

  task automatic test_directed();
    do_div("u100_7",    32'd100,        32'd7,          1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("s_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("s_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("u5_0",      32'd5,          32'd0,          1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("s5_0",      32'd5,          32'd0,          1'b1, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("u9_3",      32'd9,          32'd3,          1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("u0_9",      32'd0,          32'd9,          1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("u_max_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    do_div("u_lt",      32'd3,          32'hFFFF_FFFF,  1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_ignore_start();
    do_div("poke100_7", 32'd100, 32'd7, 1'b0, 10, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_div("b2b_first",  32'd100,       32'd7, 1'b0, 0, 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
    do_div("b2b_second", 32'hFFFF_FF9C, 32'd7, 1'b1, 0, 1'b1, 1'b1, 32'd42, 32'd0, 1'b0);
    do_div("b2b_dz",     32'd42,        32'd0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_mid busy/done: got %b/%b expected 0/0", busy, done); end
    n_cmp++; if (quotient !== 32'd0 || remainder !== 32'd0) begin n_bad++; $display("FAIL reset_mid results: got %h/%h expected 0/0", quotient, remainder); end
    n_cmp++; if (flags !== 4'b0100 || div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_mid flags: got %b dz=%b expected 0100 dz=0", flags, div_by_zero); end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL reset_mid aborted_done: got 1 expected 0"); end
    prev_q = '0; prev_r = '0;
    do_div("after_reset", 32'd100, 32'd7, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = ($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (i % 5 == 0) a = 32'h8000_0000;
      do_div($sformatf("rand%0d", i), a, b, s, 0, 1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
